// File: rtl/servo_ramp_controller.sv
// -----------------------------------------------------------------------------
// servo_ramp_controller
//
// Purpose:
//   Two-channel duty-cycle ramp generator sitting behind a custom-instruction
//   port. Software writes a target and a step per channel; once per frame
//   (2^FRAME_BITS cycles) each channel moves its current duty one step toward
//   its target, landing exactly on it. The current duty feeds a downstream PWM
//   stage together with a one-cycle load strobe.
//
// Handshake:
//   The instruction port is single-cycle. select = start & (ciN == customId).
//   done mirrors select combinationally and result is valid in that same
//   cycle. Any write takes effect at the clock edge that ends the select
//   cycle. There is no back-pressure.
//
// Ports:
//   clock    in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   custom-instruction strobe
//   ciN      in   8   custom-instruction number
//   valueA   in  32   [1:0] opcode, [2] channel select
//   valueB   in  32   operand, [19:0] used
//   done     out  1   instruction completion (combinational)
//   result   out 32   read data, zero when not selected
//   dutyOut0 out 20   channel 0 current duty
//   dutyOut1 out 20   channel 1 current duty
//   dutyLoad out  2   per-channel strobe, high in the first cycle a new duty
//                     value is presented
//   rampIrq  out  1   one-cycle arrival pulse (only with SERVO_RAMP_IRQ_EN)
//
// Opcodes:
//   00 target[ch] = min(valueB[19:0], MAX_DUTY)
//   01 step[ch]   = valueB[19:0]        (0 = jump straight to target)
//   10 result     = {12'b0, current[ch]}
//   11 result     = {28'b0, ramping[1:0], arrived[1:0]}, clears arrived
//
// Configuration macro:
//   SERVO_RAMP_IRQ_EN  when defined, rampIrq pulses for one cycle whenever
//                      either channel reaches its target; otherwise rampIrq
//                      is tied to 0.
// -----------------------------------------------------------------------------
module servo_ramp_controller #(
    parameter logic [7:0]  customId   = 8'h00,
    parameter int          FRAME_BITS = 20,
    parameter logic [19:0] MAX_DUTY   = 20'hFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic [19:0] dutyOut0,
    output logic [19:0] dutyOut1,
    output logic [1:0]  dutyLoad,
    output logic        rampIrq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_t;

    // Registered state
    logic [FRAME_BITS-1:0] r_frame_cnt;
    logic [19:0]           r_current [2];
    logic [19:0]           r_target  [2];
    logic [19:0]           r_step    [2];
    ramp_state_t           r_state   [2];
    logic [1:0]            r_arrived;
    logic [1:0]            r_load;

    // Decode
    logic        w_select;
    logic [1:0]  w_op;
    logic        w_ch;
    logic [19:0] w_target_clamped;
    logic        w_tick;
    logic        w_clr_arrived;
    logic        w_unused_bits;

    // Per-channel next-state
    logic [20:0] w_sum      [2];
    logic [20:0] w_dif      [2];
    logic [19:0] w_cur_next [2];
    ramp_state_t w_state_next [2];
    logic [1:0]  w_arrive;
    logic [1:0]  w_ramping;

    assign w_select         = start && (ciN == customId);
    assign w_op             = valueA[1:0];
    assign w_ch             = valueA[2];
    assign w_target_clamped = (valueB[19:0] > MAX_DUTY) ? MAX_DUTY : valueB[19:0];
    assign w_tick           = &r_frame_cnt;
    assign w_clr_arrived    = w_select && (w_op == 2'b11);
    assign w_unused_bits    = &{1'b0, valueA[31:3], valueB[31:20]};

    assign done     = w_select;
    assign dutyOut0 = r_current[0];
    assign dutyOut1 = r_current[1];
    assign dutyLoad = r_load;

    always_comb begin
        result = 32'd0;
        if (w_select) begin
            case (w_op)
                2'b10:   result = {12'd0, r_current[w_ch]};
                2'b11:   result = {28'd0, w_ramping, r_arrived};
                default: result = 32'd0;
            endcase
        end
    end

    // Stepping is gated by both the state and the live comparison, so a tick
    // that lands in the single cycle between a reversing target write and the
    // state catching up simply does not move. The tick always compares against
    // the target register as it stood before this edge, so a target written in
    // the tick cycle only takes effect from the next tick.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_sum[i]        = {1'b0, r_current[i]} + {1'b0, r_step[i]};
            w_dif[i]        = {1'b0, r_current[i]} - {1'b0, r_step[i]};
            w_cur_next[i]   = r_current[i];
            w_state_next[i] = r_state[i];
            w_arrive[i]     = 1'b0;
            w_ramping[i]    = (r_state[i] != ST_IDLE);

            if (w_tick && (r_state[i] == ST_UP) && (r_target[i] > r_current[i])) begin
                if ((r_step[i] == 20'd0) || (w_sum[i] >= {1'b0, r_target[i]}))
                    w_cur_next[i] = r_target[i];
                else
                    w_cur_next[i] = w_sum[i][19:0];
            end else if (w_tick && (r_state[i] == ST_DOWN) && (r_target[i] < r_current[i])) begin
                // w_dif[20] is the borrow: stepping below zero clamps to target.
                if ((r_step[i] == 20'd0) || w_dif[i][20] || (w_dif[i][19:0] <= r_target[i]))
                    w_cur_next[i] = r_target[i];
                else
                    w_cur_next[i] = w_dif[i][19:0];
            end

            if (r_target[i] > w_cur_next[i])
                w_state_next[i] = ST_UP;
            else if (r_target[i] < w_cur_next[i])
                w_state_next[i] = ST_DOWN;
            else
                w_state_next[i] = ST_IDLE;

            // Arrival is a ramp ending, not an idle channel staying idle.
            w_arrive[i] = (r_state[i] != ST_IDLE) && (w_state_next[i] == ST_IDLE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_arrived   <= 2'b00;
            r_load      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_current[i] <= 20'd0;
                r_target[i]  <= 20'd0;
                r_step[i]    <= 20'd1;
                r_state[i]   <= ST_IDLE;
            end
        end else begin
            r_frame_cnt <= r_frame_cnt + {{(FRAME_BITS-1){1'b0}}, 1'b1};
            for (int i = 0; i < 2; i++) begin
                r_current[i] <= w_cur_next[i];
                r_state[i]   <= w_state_next[i];
                r_load[i]    <= (w_cur_next[i] != r_current[i]);
                // A new arrival wins over a same-cycle status-read clear.
                r_arrived[i] <= w_arrive[i] | (r_arrived[i] & ~w_clr_arrived);
            end
            if (w_select && (w_op == 2'b00))
                r_target[w_ch] <= w_target_clamped;
            if (w_select && (w_op == 2'b01))
                r_step[w_ch] <= valueB[19:0];
        end
    end

`ifdef SERVO_RAMP_IRQ_EN
    logic r_irq;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_irq <= 1'b0;
        else
            r_irq <= |w_arrive;
    end

    assign rampIrq = r_irq;
`else
    assign rampIrq = 1'b0;
`endif

endmodule

// File: doc/servo_ramp_controller.md
SERVO_RAMP_CONTROLLER -- requirements
Module: servo_ramp_controller

Interface
REQ-001 SHALL have parameter customId, default 8'h00, custom-instruction number the block answers to.
REQ-002 SHALL have parameter FRAME_BITS, default 20, width of the internal frame counter; frame period = 2^FRAME_BITS cycles, matching the downstream PWM counter.
REQ-003 SHALL have parameter MAX_DUTY, default 20'hFFFFF, upper clamp on any target.
REQ-004 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  custom-instruction strobe.
REQ-007 SHALL have port ciN  input  8  custom-instruction number.
REQ-008 SHALL have port valueA  input  32  [1:0] opcode, [2] channel select.
REQ-009 SHALL have port valueB  input  32  operand; only [19:0] used.
REQ-010 SHALL have port done  output  1  instruction completion.
REQ-011 SHALL have port result  output  32  read data; zero when not selected.
REQ-012 SHALL have port dutyOut0 / dutyOut1  output  20 each  current ramped duty per channel, to PWM stage.
REQ-013 SHALL have port dutyLoad  output  2  one-cycle strobe per channel when the matching dutyOut changes.
REQ-014 SHALL have port rampIrq  output  1  arrival pulse (see Configuration).

Function
REQ-015 SHALL decode select = (ciN == customId) & start; done SHALL equal select combinationally (zero-latency).
REQ-016 Opcode 00 SHALL latch target[ch] = min(valueB[19:0], MAX_DUTY) at the clock edge.
REQ-017 Opcode 01 SHALL latch step[ch] = valueB[19:0].
REQ-018 Opcode 10 SHALL drive result = {12'b0, current[ch]} in the same cycle as done.
REQ-019 Opcode 11 SHALL drive result = {28'b0, ramping[1:0], arrived[1:0]}; reading SHALL clear the arrived bits at the edge.
REQ-020 Frame counter SHALL free-run, wrap at 2^FRAME_BITS-1 to 0; tick asserts for the cycle when counter = all-ones.
REQ-021 Per channel SHALL implement states IDLE, UP, DOWN: IDLE->UP if target>current, IDLE->DOWN if target<current, evaluated every cycle.
REQ-022 On tick in UP: current = min(current+step, target); in DOWN: current = max(current-step, target); arithmetic 21-bit, no wrap.
REQ-023 step = 0 SHALL mean jump: current = target on next tick.
REQ-024 On reaching target, state SHALL return to IDLE and arrived[ch] SHALL set.
REQ-025 Target write in the same cycle as tick: tick SHALL use the old target; new target applies from the next tick; direction reversal mid-ramp SHALL go UP<->DOWN without passing IDLE.
REQ-026 dutyLoad[ch] SHALL pulse in the cycle after current[ch] changes; never when unchanged.
REQ-027 Unselected cycles or unused opcodes SHALL not alter state.

Reset
REQ-028 Reset SHALL asynchronously clear counter, current, target, arrived, states to IDLE, step to 20'd1.
REQ-029 During reset SHALL drive dutyOut* = 0, dutyLoad = 0, rampIrq = 0; done/result follow REQ-015/018.
REQ-030 Reset mid-ramp SHALL abandon the ramp; first tick after release SHALL see current = 0.

Configuration
REQ-031 Macro SERVO_RAMP_IRQ_EN defined: rampIrq SHALL pulse one cycle whenever either channel sets arrived.
REQ-032 Macro undefined: rampIrq SHALL be constant 0 and no pulse logic synthesised; arrived status still readable.

Verification
REQ-033 FRAME_BITS=4; write target ch0 = 100, step 30 -> current 30,60,90,100 on successive ticks (every 16 cycles), dutyLoad[0] pulses 4 times, then IDLE.
REQ-034 current ch1 = 50, write target 0, step 0 -> current 0 on next tick, one dutyLoad[1] pulse, arrived[1] set.
REQ-035 Target 1000 with MAX_DUTY=500 -> current settles at 500, never exceeds.
REQ-036 Mid-ramp UP at 60 toward 100, write target 20 on tick cycle -> that tick gives 90, following ticks 60, 30, 20.
REQ-037 Assert reset mid-ramp -> dutyOut0 = 0 immediately without clock edge; status read returns 0.
REQ-038 Opcode 11 with SERVO_RAMP_IRQ_EN after arrival -> result[1:0] reflects arrived, cleared on next read; rampIrq pulsed exactly once.
